// File: rtl/mul12_pkg.sv
// Shared widths and pipeline latency for the 12*M constant multiplier.
// Latency depends on MUL12_INREG_EN (optional input register stage).
package mul12_pkg;

    localparam int unsigned M_W = 5;
    localparam int unsigned P_W = 11;

`ifdef MUL12_INREG_EN
    localparam int unsigned LATENCY = 4;
`else
    localparam int unsigned LATENCY = 3;
`endif

endpackage

// File: rtl/mul12_alu_stage.sv
// Combinational shift-and-add unit: p4 = M<<2, p8 = M<<3, and an 11-bit adder.
// The adder takes separate operands so the top can feed it registered partials.
module mul12_alu_stage
    import mul12_pkg::*;
(
    input  logic [M_W-1:0] i_m,
    input  logic [P_W-1:0] i_a,
    input  logic [P_W-1:0] i_b,
    output logic [P_W-1:0] o_p4,
    output logic [P_W-1:0] o_p8,
    output logic [P_W-1:0] o_sum
);

    always_comb begin
        o_p4  = {{(P_W - M_W - 2){1'b0}}, i_m, 2'b00};
        o_p8  = {{(P_W - M_W - 3){1'b0}}, i_m, 3'b000};
        // Max 31*12 = 372 fits in 11 bits, so the carry-out is dropped.
        o_sum = i_a + i_b;
    end

endmodule

// File: rtl/mul12_emu.sv
// Pipelined 12*M multiplier (S1 capture, S2 add, S3 output) with per-stage valid bits.
// Define MUL12_INREG_EN to insert an extra input register stage S0 ahead of S1.
module mul12_emu
    import mul12_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic [M_W-1:0] M_bits,
    output logic [P_W-1:0] final_product,
    output logic           product_valid
);

    logic [M_W-1:0] w_m;
    logic           w_m_valid;
    logic [P_W-1:0] w_p4;
    logic [P_W-1:0] w_p8;
    logic [P_W-1:0] w_sum;

    logic [P_W-1:0] r_p4;
    logic [P_W-1:0] r_p8;
    logic           r_s1_valid;
    logic [P_W-1:0] r_sum;
    logic           r_s2_valid;
    logic [P_W-1:0] r_prod;
    logic           r_s3_valid;

`ifdef MUL12_INREG_EN
    logic [M_W-1:0] r_s0_m;
    logic           r_s0_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s0_m     <= '0;
            r_s0_valid <= 1'b0;
        end else begin
            r_s0_m     <= M_bits;
            r_s0_valid <= 1'b1;
        end
    end

    assign w_m       = r_s0_m;
    assign w_m_valid = r_s0_valid;
`else
    assign w_m       = M_bits;
    assign w_m_valid = 1'b1;
`endif

    mul12_alu_stage u_alu (
        .i_m   (w_m),
        .i_a   (r_p4),
        .i_b   (r_p8),
        .o_p4  (w_p4),
        .o_p8  (w_p8),
        .o_sum (w_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_p4       <= '0;
            r_p8       <= '0;
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_s2_valid <= 1'b0;
            r_prod     <= '0;
            r_s3_valid <= 1'b0;
        end else begin
            r_p4       <= w_p4;
            r_p8       <= w_p8;
            r_s1_valid <= w_m_valid;
            r_sum      <= w_sum;
            r_s2_valid <= r_s1_valid;
            r_prod     <= r_sum;
            r_s3_valid <= r_s2_valid;
        end
    end

    assign final_product = r_prod;
    assign product_valid = r_s3_valid;

endmodule

// File: tb/tb_mul12_emu.sv
// Self-checking bench for mul12_emu: expected outputs come from a history-based
// model (12*M of the operand sampled Lat edges ago, zero if a reset fell in that window).
module tb_mul12_emu;

`ifdef MUL12_INREG_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 3;
`endif

    logic        clock;
    logic        reset;
    logic [4:0]  M_bits;
    logic [10:0] final_product;
    logic        product_valid;

    int total;
    int bad;

    // One entry per rising edge: operand and reset seen at that edge.
    int hist_m[$];
    bit hist_rst[$];

    logic [10:0] exp_p;
    logic        exp_v;

    mul12_emu dut (
        .clock         (clock),
        .reset         (reset),
        .M_bits        (M_bits),
        .final_product (final_product),
        .product_valid (product_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output after the latest edge: the operand from Lat edges back, unless flushed.
    function automatic void model(output logic [10:0] p, output logic v);
        int n;
        n = hist_m.size();
        p = '0;
        v = 1'b0;
        for (int j = 0; j < Lat; j++) begin
            if (j < n && hist_rst[n - 1 - j]) return;
        end
        if (n >= Lat) begin
            p = 11'(12 * hist_m[n - Lat]);
            v = 1'b1;
        end
    endfunction

    task automatic step(input int m, input bit rst);
        M_bits = 5'(m);
        reset  = rst;
        @(posedge clock);
        hist_m.push_back(m);
        hist_rst.push_back(rst);
        #1;
        model(exp_p, exp_v);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step($urandom_range(0, 31), 1'b1);
            total++;
            if (final_product !== 11'd0 || product_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got prod=%0d valid=%b want prod=0 valid=0",
                         final_product, product_valid);
            end
        end
        for (int i = 1; i <= Lat + 2; i++) begin
            step(0, 1'b0);
            total++;
            if (final_product !== 11'd0 || product_valid !== (i >= Lat)) begin
                bad++;
                $display("FAIL reset_release edge%0d: got prod=%0d valid=%b want prod=0 valid=%b",
                         i, final_product, product_valid, (i >= Lat));
            end
        end
    endtask

    task automatic test_stream();
        int ops[4] = '{15, 5, 10, 10};
        for (int i = 0; i < 4 + Lat; i++) begin
            step(i < 4 ? ops[i] : 0, 1'b0);
            total++;
            if (final_product !== exp_p || product_valid !== exp_v) begin
                bad++;
                $display("FAIL stream step%0d: got prod=%0d valid=%b want prod=%0d valid=%b",
                         i, final_product, product_valid, exp_p, exp_v);
            end
        end
    endtask

    task automatic test_boundary();
        int ops[3] = '{0, 31, 1};
        for (int i = 0; i < 3 + Lat; i++) begin
            step(i < 3 ? ops[i] : 0, 1'b0);
            total++;
            if (final_product !== exp_p || product_valid !== exp_v) begin
                bad++;
                $display("FAIL boundary step%0d: got prod=%0d valid=%b want prod=%0d valid=%b",
                         i, final_product, product_valid, exp_p, exp_v);
            end
            if (exp_p == 11'd372) begin
                total++;
                if (final_product[10:9] !== 2'b00 || final_product[8:0] !== 9'd372) begin
                    bad++;
                    $display("FAIL boundary_372_width: got %b want 00101110100", final_product);
                end
            end
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) step($urandom_range(1, 31), 1'b0);
        step($urandom_range(0, 31), 1'b1);
        total++;
        if (final_product !== 11'd0 || product_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_edge: got prod=%0d valid=%b want prod=0 valid=0",
                     final_product, product_valid);
        end
        for (int i = 0; i < Lat + 3; i++) begin
            step($urandom_range(0, 31), 1'b0);
            total++;
            if (final_product !== exp_p || product_valid !== exp_v) begin
                bad++;
                $display("FAIL flush_after step%0d: got prod=%0d valid=%b want prod=%0d valid=%b",
                         i, final_product, product_valid, exp_p, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < Lat; i++) step(7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(7, 1'b0);
            total++;
            if (final_product !== 11'd84 || product_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_7 cycle%0d: got prod=%0d valid=%b want prod=84 valid=1",
                         i, final_product, product_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 31), ($urandom_range(0, 15) == 0));
            total++;
            if (final_product !== exp_p || product_valid !== exp_v) begin
                bad++;
                $display("FAIL random step%0d: got prod=%0d valid=%b want prod=%0d valid=%b",
                         i, final_product, product_valid, exp_p, exp_v);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        M_bits = '0;
        test_reset();
        test_stream();
        test_boundary();
        test_reset_flush();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
